// File: rtl/issue_ctl.sv
// issue_ctl: dual-issue instruction queue picking 0-2 head instructions per cycle under GPR port, pair-hazard and scoreboard limits
module issue_ctl #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fetch_valid,
  input  logic [0:63]            fetch_data,
  output logic                   fetch_ready,
  input  logic                   flush,
  input  logic                   issue_hold,
  output logic                   issue0_valid,
  output logic [0:31]            issue0_inst,
  output logic                   issue1_valid,
  output logic [0:31]            issue1_inst,
  output logic [0:$clog2(DEPTH)] q_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LIM = (AW+1)'(DEPTH - 2);
  typedef struct packed {
    logic       solo;
    logic [1:0] nr;
    logic [1:0] nw;
    logic       r0v;
    logic       r1v;
    logic       w0v;
    logic       w1v;
    logic [4:0] r0;
    logic [4:0] r1;
    logic [4:0] w0;
    logic [4:0] w1;
  } dec_t;
  function automatic dec_t decode(input logic [0:31] i);
    dec_t d;
    logic [5:0] op;
    logic [4:0] rt, ra, rb;
    op = i[0:5];
    rt = i[6:10];
    ra = i[11:15];
    rb = i[16:20];
    d = '0;
    if (op == 6'd31 && i[22:30] == 9'd266) begin
      d.r0v = 1'b1; d.r0 = ra; d.r1v = rb != ra; d.r1 = rb; d.w0v = 1'b1; d.w0 = rt;
    end else if (op == 6'd31 && i[21:30] == 10'd444) begin
      d.r0v = 1'b1; d.r0 = rt; d.r1v = rb != rt; d.r1 = rb; d.w0v = 1'b1; d.w0 = ra;
    end else if (op == 6'd14 || (op == 6'd58 && i[30:31] == 2'b00)) begin
      d.r0v = ra != 5'd0; d.r0 = ra; d.w0v = 1'b1; d.w0 = rt;
    end else if (op == 6'd58 && i[30:31] == 2'b01) begin
      d.r0v = 1'b1; d.r0 = ra; d.w0v = 1'b1; d.w0 = rt; d.w1v = ra != rt; d.w1 = ra;
    end else if (op == 6'd62 && i[30:31] == 2'b00) begin
      d.r0v = ra != 5'd0 && ra != rt; d.r0 = ra; d.r1v = 1'b1; d.r1 = rt;
    end else begin
      d.solo = 1'b1; d.r0v = op == 6'd17; d.r0 = 5'd0; d.r1v = op == 6'd17; d.r1 = 5'd3;
    end
    d.nr = {1'b0, d.r0v} + {1'b0, d.r1v};
    d.nw = {1'b0, d.w0v} + {1'b0, d.w1v};
    return d;
  endfunction
  function automatic logic hit(input logic v, input logic [4:0] r, input dec_t d);
    return v && ((d.w0v && d.w0 == r) || (d.w1v && d.w1 == r));
  endfunction
  logic [0:31]   mem [DEPTH];
  logic [1:0]    sb [32];
  logic [AW-1:0] head, tail, nxt;
  logic [AW:0]   count;
  logic [1:0]    pops;
  logic          push, iss0, iss1, ok0, ok1;
  dec_t          d0, d1;
  assign nxt = head + AW'(1);
  assign d0 = decode(mem[head]);
  assign d1 = decode(mem[nxt]);
  assign ok0 = !(d0.r0v && sb[d0.r0] != 2'd0) && !(d0.r1v && sb[d0.r1] != 2'd0);
  assign ok1 = !(d1.r0v && sb[d1.r0] != 2'd0) && !(d1.r1v && sb[d1.r1] != 2'd0);
  assign fetch_ready = count <= LIM;
  assign push = fetch_valid && fetch_ready && !flush;
  assign iss0 = count != '0 && !issue_hold && !flush && ok0;
  assign iss1 = iss0 && count > (AW+1)'(1) && !d0.solo && !d1.solo && ok1 &&
                {1'b0, d0.nr} + {1'b0, d1.nr} <= 3'd2 && {1'b0, d0.nw} + {1'b0, d1.nw} <= 3'd2 &&
                !hit(d1.r0v, d1.r0, d0) && !hit(d1.r1v, d1.r1, d0) &&
                !hit(d1.w0v, d1.w0, d0) && !hit(d1.w1v, d1.w1, d0);
  assign pops = {1'b0, iss0} + {1'b0, iss1};
  assign q_count = count;
  always_ff @(posedge clk) begin
    head <= (reset || flush) ? '0 : head + AW'(pops);
    tail <= (reset || flush) ? '0 : tail + (push ? AW'(2) : '0);
    count <= (reset || flush) ? '0 : count + (push ? (AW+1)'(2) : '0) - (AW+1)'(pops);
    issue0_valid <= !reset && iss0;
    issue0_inst <= (!reset && iss0) ? mem[head] : '0;
    issue1_valid <= !reset && iss1;
    issue1_inst <= (!reset && iss1) ? mem[nxt] : '0;
    for (int r = 0; r < 32; r++)
      sb[r] <= reset ? 2'd0 :
               (hit(iss0, 5'(r), d0) || hit(iss1, 5'(r), d1)) ? 2'd2 :
               sb[r] - {1'b0, sb[r] != 2'd0};
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= fetch_data[0:31];
      mem[tail + AW'(1)] <= fetch_data[32:63];
    end
  end
endmodule
